reconhecedor_digito: RTL and testbench
======================================

# reconhecedor_digito

Streaming digit classifier for the DE2 video path. Accepts one IMG_W×IMG_H grayscale patch as a pixel stream and compares it against NUM_CLASSES run-time-loadable templates in parallel. Per class, it accumulates a per-pixel difference score, then picks the best-matching class by sequential argmin. It replaces the fixed per-digit, per-pixel combinational difference arrays with one parametrised, sequential block.

## Interface
- IMG_W, 11, patch width in pixels
- IMG_H, 11, patch height in pixels
- PIX_W, 8, pixel and template sample width
- NUM_CLASSES, 10, number of templates (digits 0..9)
- ACC_W, 15, score accumulator width; saturating
- CLS_W, 4, class index width, ≥ clog2(NUM_CLASSES)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tpl_we  in  1  template write strobe; honoured only in IDLE
- tpl_class  in  CLS_W  template class being written
- tpl_addr  in  clog2(IMG_W*IMG_H)  raster pixel index
- tpl_data  in  PIX_W  template sample
- start  in  1  begin a frame; honoured only in IDLE
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_pixel  in  PIX_W  pixel, raster order, row 0 first
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  CLS_W  best-matching class
- res_score  out  ACC_W  score of best class
- busy  out  1  state ≠ IDLE

## Operation
- Template RAM: NUM_CLASSES × IMG_W*IMG_H × PIX_W, with a registered read port.
  - Write: mem[tpl_class][tpl_addr] ← tpl_data when tpl_we in IDLE.
  - Writes outside IDLE and writes with tpl_class ≥ NUM_CLASSES are ignored.
- FSM states: IDLE, ACCUM, FLUSH, SEARCH, DONE.
  - IDLE: start=1 clears all accumulators and the pixel counter, then → ACCUM.
  - ACCUM: in_ready=1. Each accepted pixel registers the pixel and reads all classes at the counter address, then increments the counter. Acceptance of pixel index IMG_W*IMG_H−1 → FLUSH.
  - FLUSH: one cycle; the last pipelined difference is added to the accumulators. → SEARCH.
  - SEARCH: NUM_CLASSES cycles, one class per cycle from class 0.
    - Best is updated only when score < best, so ties resolve to the lowest index.
    - After the last class → DONE.
  - DONE: res_valid=1, with res_class and res_score stable. res_ready=1 → IDLE on the same edge.
- Per-pixel term: d = |pixel − tpl|, PIX_W bits, unsigned.
- Accumulation: acc[c] ← min(acc[c] + term, 2^ACC_W − 1). The accumulator saturates and never wraps.
- start outside IDLE is ignored.
- in_valid outside ACCUM is ignored, and in_ready=0 there.
- tpl_we and start asserted together in IDLE: the write is performed, and the frame starts next cycle.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 0, res_valid = 0, busy = 0
  - res_class = 0, res_score = 0
  - accumulators and counter = 0
  - template RAM contents are not reset.
- Reset asserted mid-frame returns to IDLE immediately. The partial frame is discarded, and a fresh start is required.
- Pipeline: the accept edge registers pixel and address, the next edge accumulates.
- Latency: if the last pixel is accepted in cycle T, FLUSH is T+1, SEARCH is T+2..T+1+NUM_CLASSES, and res_valid first rises in cycle T+2+NUM_CLASSES. With defaults that is T+12.
- Throughput: one pixel per cycle while in_valid is held. Gaps in in_valid stall without loss.
- res_valid is held with stable outputs for any res_ready delay. It falls in the cycle after the handshake edge.
- Minimum frame period: IMG_W*IMG_H + NUM_CLASSES + 3 cycles (one start cycle in IDLE).

## Configuration
- DIFF_QUADRATICA_EN:
  - Defined: term = (d*d) >> PIX_W, PIX_W bits, squared-error ("Euclidean") scoring.
  - Undefined: term = d (absolute difference).
- ACC_W, the saturation rule and all timing are identical in both builds.

## Test plan
- Exact match: load class c with all samples = 20·c and stream 121 pixels of 60. Expect res_class=3 and res_score=0 at 12 cycles after the last pixel.
- Tie: load class c with all samples = 20·c and stream all pixels of 30. Classes 1 and 2 both score 1210, so expect res_class=1 and res_score=1210.
- Saturation (ACC_W=10): class 0 templates = 0, other classes = 255, stream all pixels of 255. Class 0 saturates and scores 1023 while classes 1..9 score 0, so expect res_class=1 and res_score=0.
- Handshake stress: randomly drop in_valid for 0–5 cycles and hold res_ready=0 for 20 cycles. Expect the result identical to the unstalled run, res_valid held steady, and tpl_we during the frame having no effect.
- Reset mid-frame: assert rst_n=0 after 50 pixels. Expect all outputs at reset values. Then start and stream a full frame and expect the correct result.
- DIFF_QUADRATICA_EN build: templates 0 and all pixels 16. Expect per-pixel term 1 and res_score=121 for every class, so res_class=0.

Source files
------------

// File: rtl/reconhecedor_digito_if.sv
// rtl/reconhecedor_digito_if.sv - template load, pixel stream and result bus for reconhecedor_digito
interface reconhecedor_digito_if #(
  parameter int IMG_W = 11,
  parameter int IMG_H = 11,
  parameter int PIX_W = 8,
  parameter int ACC_W = 15,
  parameter int CLS_W = 4
) ();
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);

  logic              tpl_we;
  logic [CLS_W-1:0]  tpl_class;
  logic [ADDR_W-1:0] tpl_addr;
  logic [PIX_W-1:0]  tpl_data;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_pixel;
  logic              res_valid;
  logic              res_ready;
  logic [CLS_W-1:0]  res_class;
  logic [ACC_W-1:0]  res_score;
  logic              busy;

  modport master (
    output tpl_we, tpl_class, tpl_addr, tpl_data, start, in_valid, in_pixel, res_ready,
    input  in_ready, res_valid, res_class, res_score, busy
  );

  modport slave (
    input  tpl_we, tpl_class, tpl_addr, tpl_data, start, in_valid, in_pixel, res_ready,
    output in_ready, res_valid, res_class, res_score, busy
  );
endinterface

// File: rtl/reconhecedor_digito.sv
// rtl/reconhecedor_digito.sv - streaming template-matching digit classifier; DIFF_QUADRATICA_EN selects squared-error scoring
module reconhecedor_digito #(
  parameter int IMG_W       = 11,
  parameter int IMG_H       = 11,
  parameter int PIX_W       = 8,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 15,
  parameter int CLS_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  reconhecedor_digito_if.slave bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_SEARCH = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CLS_W-1:0]  idx_q;

  logic [PIX_W-1:0]  mem_q [NUM_CLASSES][NPIX];
  logic [PIX_W-1:0]  tpl_rd_q [NUM_CLASSES];
  logic [PIX_W-1:0]  pix_q;
  logic              term_vld_q;
  logic [ACC_W-1:0]  acc_q [NUM_CLASSES];

  logic [CLS_W-1:0]  best_cls_q;
  logic [ACC_W-1:0]  best_score_q;

  logic              accept;
  logic              frame_start;
  logic              tpl_wr_en;
  logic [ACC_W-1:0]  cand_score;

  // Per-pixel distance between a streamed pixel and one template sample.
  function automatic logic [PIX_W-1:0] term_f(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] d;
`ifdef DIFF_QUADRATICA_EN
    logic [2*PIX_W-1:0] sq;
`endif
    d = (a >= b) ? (a - b) : (b - a);
`ifdef DIFF_QUADRATICA_EN
    sq = d * d;
    return sq[2*PIX_W-1:PIX_W];
`else
    return d;
`endif
  endfunction

  // Accumulator add that clamps at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [PIX_W-1:0] t);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - PIX_W){1'b0}}, t};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  // Qualifiers for pixel acceptance, frame start and template writes.
  always_comb begin
    accept      = (state_q == S_ACCUM) && bus.in_valid;
    frame_start = (state_q == S_IDLE) && bus.start;
    tpl_wr_en   = (state_q == S_IDLE) && bus.tpl_we
                  && (int'(bus.tpl_class) < NUM_CLASSES)
                  && (int'(bus.tpl_addr) < NPIX);
    cand_score  = acc_q[idx_q];
  end

  // Frame sequencing: collect pixels, drain the pipeline, scan classes, hold result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_PIX) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (idx_q == LAST_CLS) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and pixel counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Template RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (tpl_wr_en) begin
      mem_q[bus.tpl_class][bus.tpl_addr] <= bus.tpl_data;
    end
  end

  // Accept stage: capture the pixel and read every class at the same raster address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q      <= '0;
      term_vld_q <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        tpl_rd_q[c] <= '0;
      end
    end else begin
      term_vld_q <= accept;
      if (accept) begin
        pix_q <= bus.in_pixel;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          tpl_rd_q[c] <= mem_q[c][cnt_q];
        end
      end
    end
  end

  // Accumulate stage: add the previous pixel's term to every class score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else if (frame_start) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else if (term_vld_q) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= sat_add(acc_q[c], term_f(pix_q, tpl_rd_q[c]));
      end
    end
  end

  // Sequential argmin; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
    end else if (state_q == S_IDLE) begin
      idx_q <= '0;
    end else if (state_q == S_SEARCH) begin
      if ((idx_q == '0) || (cand_score < best_score_q)) begin
        best_cls_q   <= idx_q;
        best_score_q <= cand_score;
      end
      if (idx_q != LAST_CLS) begin
        idx_q <= idx_q + CLS_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res_class = best_cls_q;
  assign bus.res_score = best_score_q;

endmodule

// File: tb/tb_reconhecedor_digito.sv
// tb/tb_reconhecedor_digito.sv - table-driven scoreboard bench for reconhecedor_digito
module tb_reconhecedor_digito;
  localparam int NPIX   = 121;
  localparam int NCLS   = 10;
  localparam int LAT    = NCLS + 2;
  localparam int K_RAMP = 0;
  localparam int K_ZERO = 1;
  localparam int K_SAT  = 2;

  typedef struct {
    int cls;
    int score;
    int cls_s;
    int score_s;
  } exp_t;

  typedef struct {
    int   kind;
    int   pix;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reconhecedor_digito_if #(.ACC_W(15)) bus ();
  reconhecedor_digito_if #(.ACC_W(10)) bus_s ();

  assign bus_s.tpl_we    = bus.tpl_we;
  assign bus_s.tpl_class = bus.tpl_class;
  assign bus_s.tpl_addr  = bus.tpl_addr;
  assign bus_s.tpl_data  = bus.tpl_data;
  assign bus_s.start     = bus.start;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_pixel  = bus.in_pixel;
  assign bus_s.res_ready = bus.res_ready;

  reconhecedor_digito #(.ACC_W(15)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  reconhecedor_digito #(.ACC_W(10)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_last   = 0;
  int   n_res    = 0;
  bit   prev_valid = 1'b0;
  bit   hs_prev    = 1'b0;
  exp_t sbq[$];
  vec_t tbl[5];
  exp_t exp_tie;
  exp_t exp_rec;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: latency, drop after handshake, scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      hs_prev    = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) t_last = cyc;
      if (bus.res_valid && !prev_valid) check("latency", cyc - t_last, LAT);
      if (hs_prev) check("res_valid_fall", int'(bus.res_valid), 0);
      if (bus.res_valid && bus.res_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got unexpected result class %0d required none", bus.res_class);
        end else begin
          e = sbq.pop_front();
          check("res_class",   int'(bus.res_class),   e.cls);
          check("res_score",   int'(bus.res_score),   e.score);
          check("sat_valid",   int'(bus_s.res_valid), 1);
          check("sat_class",   int'(bus_s.res_class), e.cls_s);
          check("sat_score",   int'(bus_s.res_score), e.score_s);
        end
        n_res++;
      end
      hs_prev    = bus.res_valid && bus.res_ready;
      prev_valid = bus.res_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tpl(input int kind);
    for (int c = 0; c < NCLS; c++) begin
      for (int a = 0; a < NPIX; a++) begin
        bus.tpl_we    = 1'b1;
        bus.tpl_class = 4'(c);
        bus.tpl_addr  = 7'(a);
        case (kind)
          K_RAMP:  bus.tpl_data = 8'(20 * c);
          K_ZERO:  bus.tpl_data = 8'd0;
          default: bus.tpl_data = (c == 0) ? 8'd0 : 8'd255;
        endcase
        tick();
      end
    end
    bus.tpl_we = 1'b0;
  endtask

  task automatic stream(input int n, input int pv, input bit stall, input bit noise);
    int i = 0;
    int guard = 0;
    int gap;
    while (i < n && guard < 4000) begin
      guard++;
      if (noise) begin
        bus.tpl_we    = 1'b1;
        bus.tpl_class = 4'd2;
        bus.tpl_addr  = 7'($urandom_range(0, NPIX - 1));
        bus.tpl_data  = 8'd30;
      end
      if (stall && $urandom_range(0, 2) == 0) begin
        gap = $urandom_range(0, 5);
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'($urandom);
        repeat (gap) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'(pv);
      @(negedge clk);
      if (bus.in_ready) i++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.tpl_we   = 1'b0;
    check("stream_accepted", i, n);
  endtask

  task automatic run_frame(input int pv, input bit stall, input bit noise, input bit we_start, input exp_t e);
    @(negedge clk);
    check("in_ready_idle", int'(bus.in_ready), 0);
    check("busy_idle", int'(bus.busy), 0);
    tick();
    bus.start = 1'b1;
    if (we_start) begin
      bus.tpl_we    = 1'b1;
      bus.tpl_class = 4'd2;
      bus.tpl_addr  = 7'd0;
      bus.tpl_data  = 8'd30;
    end
    tick();
    bus.start  = 1'b0;
    bus.tpl_we = 1'b0;
    stream(NPIX, pv, stall, noise);
    sbq.push_back(e);
  endtask

  task automatic wait_result(input int target);
    int g = 0;
    while (n_res < target && g < 300) begin
      tick();
      g++;
    end
    check("result_seen", n_res, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready),  0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_busy"},      int'(bus.busy),      0);
    check({tag, "_res_class"}, int'(bus.res_class), 0);
    check({tag, "_res_score"}, int'(bus.res_score), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
    $fatal(1);
  end

  initial begin
    int cur_kind;
    int seen;
`ifdef DIFF_QUADRATICA_EN
    tbl[0] = '{K_RAMP, 60,  '{3, 0,    3, 0}};
    tbl[1] = '{K_RAMP, 30,  '{1, 0,    1, 0}};
    tbl[2] = '{K_RAMP, 175, '{8, 0,    8, 0}};
    tbl[3] = '{K_ZERO, 16,  '{0, 121,  0, 121}};
    tbl[4] = '{K_SAT,  255, '{1, 0,    1, 0}};
    exp_tie = '{1, 0, 1, 0};
    exp_rec = '{1, 0, 1, 0};
`else
    tbl[0] = '{K_RAMP, 60,  '{3, 0,    3, 0}};
    tbl[1] = '{K_RAMP, 30,  '{1, 1210, 0, 1023}};
    tbl[2] = '{K_RAMP, 175, '{9, 605,  9, 605}};
    tbl[3] = '{K_ZERO, 16,  '{0, 1936, 0, 1023}};
    tbl[4] = '{K_SAT,  255, '{1, 0,    1, 0}};
    exp_tie = '{1, 1210, 0, 1023};
    exp_rec = '{2, 1200, 0, 1023};
`endif
    bus.tpl_we    = 1'b0;
    bus.tpl_class = '0;
    bus.tpl_addr  = '0;
    bus.tpl_data  = '0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    tick();

    cur_kind = -1;
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].kind != cur_kind) begin
        load_tpl(tbl[i].kind);
        cur_kind = tbl[i].kind;
      end
      run_frame(tbl[i].pix, 1'b0, 1'b0, 1'b0, tbl[i].e);
      wait_result(i + 1);
    end

    load_tpl(K_RAMP);
    bus.res_ready = 1'b0;
    run_frame(30, 1'b1, 1'b1, 1'b0, exp_tie);
    seen = 0;
    for (int g = 0; g < 300 && seen == 0; g++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1;
    end
    check("hold_valid_seen", seen, 1);
    repeat (20) begin
      @(negedge clk);
      check("hold_valid", int'(bus.res_valid), 1);
      check("hold_class", int'(bus.res_class), exp_tie.cls);
      check("hold_score", int'(bus.res_score), exp_tie.score);
    end
    tick();
    bus.res_ready = 1'b1;
    wait_result(6);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    stream(50, 60, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid");
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("no_start_in_ready", int'(bus.in_ready), 0);
    check("no_start_busy", int'(bus.busy), 0);
    tick();
    bus.in_valid = 1'b0;
    run_frame(30, 1'b0, 1'b0, 1'b1, exp_rec);
    wait_result(7);

    check("sb_leftover", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
